mpsoc_ahb3_mem_master: RTL and testbench
========================================

Name: mpsoc_ahb3_mem_master

Overview:
Upstream bridge that converts a simple single-outstanding native memory request interface into AHB3-Lite master transfers. It drives the AHB3-Lite single-port RAM slave used in the SoC synthesis top. The block sequences the address and data phases, honours HREADY wait states and HRESP errors, and rejects misaligned requests locally. It issues only SINGLE, NONSEQ transfers, with no bursts and no locking.

Parameters:
PLEN, 8, address width in bits (matches the slave HADDR width)
XLEN, 32, data width in bits (32 only; HSIZE up to word)
TIMEOUT, 16, number of consecutive HREADY-low cycles in one transfer before the master aborts; 0 disables the timeout

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
req_i  in  1  native request strobe, sampled only in IDLE
we_i  in  1  1 = write, 0 = read
addr_i  in  PLEN  byte address
size_i  in  3  AHB HSIZE encoding: 0 = byte, 1 = half, 2 = word
wdata_i  in  XLEN  write data, already placed on the correct byte lanes by the requester
ack_o  out  1  one-cycle pulse: transfer completed OK
err_o  out  1  one-cycle pulse: transfer failed (HRESP error, misaligned, or timeout)
rdata_o  out  XLEN  read data; valid in the ack_o cycle and held until the next ack_o
busy_o  out  1  high whenever the FSM is not in IDLE
HSEL  out  1  high in ADDR state
HADDR  out  PLEN  captured address
HWDATA  out  XLEN  captured write data, driven in DATA state
HWRITE  out  1  captured we_i
HSIZE  out  3  captured size_i
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  constant 4'b0011
HTRANS  out  2  NONSEQ (2'b10) in ADDR state, IDLE (2'b00) otherwise
HMASTLOCK  out  1  constant 0
HRDATA  in  XLEN  slave read data
HREADY  in  1  bus ready
HRESP  in  1  slave error response

Behaviour:
- Clocking: one clock HCLK. Reset HRESETn is asynchronous and active-low. All state and outputs are registered.
- Reset values: FSM = IDLE, HTRANS = 00, HSEL = 0, HADDR = 0, HWDATA = 0, HWRITE = 0, HSIZE = 0, ack_o = 0, err_o = 0, rdata_o = 0, busy_o = 0, timeout counter = 0.
- Reset asserted mid-transfer: return to IDLE immediately. No ack_o or err_o is produced for the lost transfer.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - On req_i = 1, capture we_i, addr_i, size_i and wdata_i.
  - Alignment check: size 1 requires addr[0] = 0. Size 2 requires addr[1:0] = 00. size_i > 2 counts as misaligned.
  - Misaligned: pulse err_o next cycle, stay in IDLE, drive no bus activity.
  - Aligned: go to ADDR.
- ADDR:
  - Drive HTRANS = NONSEQ and HSEL = 1 with the captured fields.
  - At a rising edge with HREADY = 1, the address phase completes: go to DATA, and drive HTRANS = IDLE and HSEL = 0 from then on.
  - While HREADY = 0, hold every field stable.
- DATA:
  - Drive HWDATA = captured data.
  - HREADY = 1 and HRESP = 0 at an edge: capture HRDATA into rdata_o (reads only), pulse ack_o next cycle, go to IDLE.
  - HREADY = 1 and HRESP = 1: pulse err_o, go to IDLE. The first, HREADY-low error cycle needs no action.
- Latency with a zero-wait slave:
  - req_i sampled at edge 0.
  - ADDR drives the bus during cycle 1.
  - DATA during cycle 2.
  - ack_o high in cycle 3.
  - The next req_i is accepted in cycle 3, so back-to-back transfers run at 3 cycles each.
  - Each wait state adds one cycle.
- Timeout:
  - The counter resets on entering ADDR and on every edge where HREADY = 1.
  - It increments on each edge in ADDR or DATA where HREADY = 0.
  - When it reaches TIMEOUT, pulse err_o, force HTRANS = IDLE and go to IDLE.
  - TIMEOUT = 0 means never time out.
- ack_o and err_o are never high together.
- req_i outside IDLE is ignored; the requester must wait for ack_o or err_o.

Test Plan:
- Word write, zero-wait slave: req_i with we = 1, addr = 0x10, size = 2, wdata = 0xDEADBEEF. Expect HTRANS = 10 and HADDR = 0x10 in cycle 1, HWDATA = 0xDEADBEEF in cycle 2, ack_o pulse in cycle 3, busy_o high in cycles 1–2.
- Read with 2 wait states: read addr 0x10 after the write above, slave holds HREADY low for 2 DATA cycles. Expect ack_o in cycle 5 and rdata_o = 0xDEADBEEF; address fields stay stable throughout.
- Error response: slave drives HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1. Expect exactly one err_o pulse, no ack_o, and FSM back in IDLE.
- Misaligned request: size = 2, addr = 0x02. Expect err_o one cycle after the request with HTRANS staying 00. Also size = 1, addr = 0x03 gives err_o.
- Timeout: TIMEOUT = 4, slave holds HREADY = 0 indefinitely. Expect err_o 4 cycles after the last HREADY high, HTRANS = 00 afterwards, and a subsequent req_i accepted.
- Reset mid-transfer: drop HRESETn while in DATA. Outputs go to reset values asynchronously, with no ack_o or err_o after release; a new write then completes normally.

Source files
------------

// File: rtl/mpsoc_ahb3_mem_master.sv
// mpsoc_ahb3_mem_master
// Bridges a single-outstanding native memory request port onto an AHB3-Lite
// master. Only SINGLE/NONSEQ transfers are issued. Misaligned requests are
// rejected locally without touching the bus. A stalled slave is abandoned
// after TIMEOUT consecutive HREADY-low cycles (TIMEOUT = 0 disables this).

module mpsoc_ahb3_mem_master #(
    parameter int PLEN    = 8,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic            req_i,
    input  logic            we_i,
    input  logic [PLEN-1:0] addr_i,
    input  logic [2:0]      size_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            ack_o,
    output logic            err_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            busy_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Counter wide enough to hold TIMEOUT itself; at least one bit.
    localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TLIMIT = TW'(TIMEOUT);

    logic [1:0]      state;
    logic [XLEN-1:0] wdata_q;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tcnt_inc;
    logic            misaligned;
    logic            timeout_hit;

    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    assign tcnt_inc    = tcnt + TW'(1);
    assign timeout_hit = (TIMEOUT != 0) && !HREADY && (tcnt_inc == TLIMIT);

    // Decide whether the incoming request's address suits its transfer size.
    always_comb begin
        misaligned = 1'b0;
        case (size_i)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = addr_i[0];
            3'd2:    misaligned = addr_i[1] | addr_i[0];
            default: misaligned = 1'b1;
        endcase
    end

    // Transfer sequencer: request capture, address phase, data phase, abort.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            HTRANS  <= TRANS_IDLE;
            HSEL    <= 1'b0;
            HADDR   <= '0;
            HWDATA  <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= 3'd0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
            busy_o  <= 1'b0;
            tcnt    <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        if (misaligned) begin
                            err_o <= 1'b1;
                        end else begin
                            state   <= ST_ADDR;
                            busy_o  <= 1'b1;
                            HSEL    <= 1'b1;
                            HTRANS  <= TRANS_NONSEQ;
                            HADDR   <= addr_i;
                            HWRITE  <= we_i;
                            HSIZE   <= size_i;
                            wdata_q <= wdata_i;
                            tcnt    <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_DATA;
                        HSEL   <= 1'b0;
                        HTRANS <= TRANS_IDLE;
                        HWDATA <= wdata_q;
                        tcnt   <= '0;
                    end else if (timeout_hit) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        HSEL   <= 1'b0;
                        HTRANS <= TRANS_IDLE;
                        err_o  <= 1'b1;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        tcnt   <= '0;
                        if (HRESP) begin
                            err_o <= 1'b1;
                        end else begin
                            ack_o <= 1'b1;
                            if (!HWRITE) begin
                                rdata_o <= HRDATA;
                            end
                        end
                    end else if (timeout_hit) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    HSEL   <= 1'b0;
                    HTRANS <= TRANS_IDLE;
                    tcnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_mem_master.sv
// tb_mpsoc_ahb3_mem_master
// Directed bench for the AHB3-Lite memory master. The bench plays the slave
// by driving HREADY/HRESP/HRDATA by hand and checks the bus and native
// outputs cycle by cycle against hand-computed values.

module tb_mpsoc_ahb3_mem_master;

    logic        HCLK;
    logic        HRESETn;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int total;
    int bad;

    mpsoc_ahb3_mem_master #(
        .PLEN    (8),
        .XLEN    (32),
        .TIMEOUT (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .size_i    (size),
        .wdata_i   (wdata),
        .ack_o     (ack),
        .err_o     (err),
        .rdata_o   (rdata),
        .busy_o    (busy),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    // Free-running bus clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic        r,
                                 input logic        w,
                                 input logic [7:0]  a,
                                 input logic [2:0]  s,
                                 input logic [31:0] d);
        req   = r;
        we    = w;
        addr  = a;
        size  = s;
        wdata = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        total   = 0;
        bad     = 0;
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        HRDATA  = 32'h0;
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_htrans", 32'(HTRANS), 32'h0);
        checkOutput("rst_hsel",   32'(HSEL),   32'h0);
        checkOutput("rst_busy",   32'(busy),   32'h0);
        checkOutput("rst_ack",    32'(ack),    32'h0);
        checkOutput("rst_err",    32'(err),    32'h0);
        checkOutput("rst_rdata",  rdata,       32'h0);
        checkOutput("const_hburst", 32'(HBURST),    32'h0);
        checkOutput("const_hprot",  32'(HPROT),     32'h3);
        checkOutput("const_hlock",  32'(HMASTLOCK), 32'h0);
        HRESETn = 1'b1;
        tick();

        // Word write, zero-wait slave
        $display("[TB] word write, zero wait");
        HRDATA = 32'h55555555;
        applyStimulus(1'b1, 1'b1, 8'h10, 3'd2, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("wr_c1_htrans", 32'(HTRANS), 32'h2);
        checkOutput("wr_c1_hsel",   32'(HSEL),   32'h1);
        checkOutput("wr_c1_haddr",  32'(HADDR),  32'h10);
        checkOutput("wr_c1_hwrite", 32'(HWRITE), 32'h1);
        checkOutput("wr_c1_hsize",  32'(HSIZE),  32'h2);
        checkOutput("wr_c1_busy",   32'(busy),   32'h1);
        tick();
        checkOutput("wr_c2_htrans", 32'(HTRANS), 32'h0);
        checkOutput("wr_c2_hsel",   32'(HSEL),   32'h0);
        checkOutput("wr_c2_hwdata", HWDATA,      32'hDEADBEEF);
        checkOutput("wr_c2_busy",   32'(busy),   32'h1);
        checkOutput("wr_c2_ack",    32'(ack),    32'h0);
        tick();
        checkOutput("wr_c3_ack",   32'(ack),  32'h1);
        checkOutput("wr_c3_err",   32'(err),  32'h0);
        checkOutput("wr_c3_busy",  32'(busy), 32'h0);
        checkOutput("wr_c3_rdata", rdata,     32'h0);
        tick();
        checkOutput("wr_c4_ack", 32'(ack), 32'h0);

        // Read with two data-phase wait states
        $display("[TB] read, two wait states");
        applyStimulus(1'b1, 1'b0, 8'h10, 3'd2, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("rd_c1_htrans", 32'(HTRANS), 32'h2);
        checkOutput("rd_c1_hwrite", 32'(HWRITE), 32'h0);
        tick();
        HREADY = 1'b0;
        HRDATA = 32'h0BADF00D;
        tick();
        checkOutput("rd_c3_htrans", 32'(HTRANS), 32'h0);
        checkOutput("rd_c3_haddr",  32'(HADDR),  32'h10);
        checkOutput("rd_c3_hsize",  32'(HSIZE),  32'h2);
        checkOutput("rd_c3_ack",    32'(ack),    32'h0);
        checkOutput("rd_c3_busy",   32'(busy),   32'h1);
        tick();
        checkOutput("rd_c4_ack",   32'(ack),    32'h0);
        checkOutput("rd_c4_haddr", 32'(HADDR),  32'h10);
        HREADY = 1'b1;
        HRDATA = 32'hDEADBEEF;
        tick();
        checkOutput("rd_c5_ack",   32'(ack), 32'h1);
        checkOutput("rd_c5_err",   32'(err), 32'h0);
        checkOutput("rd_c5_rdata", rdata,    32'hDEADBEEF);
        HRDATA = 32'h0;
        tick();
        checkOutput("rd_c6_ack",   32'(ack), 32'h0);
        checkOutput("rd_c6_rdata", rdata,    32'hDEADBEEF);

        // Error response, with one address-phase wait first
        $display("[TB] error response");
        applyStimulus(1'b1, 1'b1, 8'h20, 3'd2, 32'h12345678);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        HREADY = 1'b0;
        tick();
        checkOutput("er_addrwait_htrans", 32'(HTRANS), 32'h2);
        checkOutput("er_addrwait_haddr",  32'(HADDR),  32'h20);
        checkOutput("er_addrwait_hsel",   32'(HSEL),   32'h1);
        HREADY = 1'b1;
        tick();
        checkOutput("er_data_hwdata", HWDATA, 32'h12345678);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        checkOutput("er_first_err", 32'(err), 32'h0);
        checkOutput("er_first_ack", 32'(ack), 32'h0);
        HREADY = 1'b1;
        tick();
        checkOutput("er_err",   32'(err),  32'h1);
        checkOutput("er_ack",   32'(ack),  32'h0);
        checkOutput("er_busy",  32'(busy), 32'h0);
        checkOutput("er_rdata", rdata,     32'hDEADBEEF);
        HRESP = 1'b0;
        tick();
        checkOutput("er_after_err", 32'(err), 32'h0);
        checkOutput("er_after_ack", 32'(ack), 32'h0);

        // Misaligned requests are rejected without bus activity
        $display("[TB] misaligned requests");
        applyStimulus(1'b1, 1'b0, 8'h02, 3'd2, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("mis_w_err",    32'(err),    32'h1);
        checkOutput("mis_w_ack",    32'(ack),    32'h0);
        checkOutput("mis_w_htrans", 32'(HTRANS), 32'h0);
        checkOutput("mis_w_busy",   32'(busy),   32'h0);
        tick();
        checkOutput("mis_w_after", 32'(err), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h03, 3'd1, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("mis_h_err",    32'(err),    32'h1);
        checkOutput("mis_h_htrans", 32'(HTRANS), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 3'd3, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("mis_sz3_err", 32'(err), 32'h1);
        tick();

        // Byte read at an odd address is legal
        $display("[TB] byte read at odd address");
        applyStimulus(1'b1, 1'b0, 8'h03, 3'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("byte_htrans", 32'(HTRANS), 32'h2);
        checkOutput("byte_haddr",  32'(HADDR),  32'h03);
        checkOutput("byte_hsize",  32'(HSIZE),  32'h0);
        checkOutput("byte_err",    32'(err),    32'h0);
        tick();
        HRDATA = 32'hAB000000;
        tick();
        checkOutput("byte_ack",   32'(ack), 32'h1);
        checkOutput("byte_rdata", rdata,    32'hAB000000);
        tick();

        // Timeout after four consecutive HREADY-low data cycles
        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, 8'h04, 3'd2, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("to_wait%0d_err", i),  32'(err),  32'h0);
            checkOutput($sformatf("to_wait%0d_busy", i), 32'(busy), 32'h1);
        end
        tick();
        checkOutput("to_err",    32'(err),    32'h1);
        checkOutput("to_ack",    32'(ack),    32'h0);
        checkOutput("to_htrans", 32'(HTRANS), 32'h0);
        checkOutput("to_busy",   32'(busy),   32'h0);
        checkOutput("to_rdata",  rdata,       32'hAB000000);
        HREADY = 1'b1;
        HRDATA = 32'hCAFEF00D;
        applyStimulus(1'b1, 1'b0, 8'h08, 3'd2, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("to_next_htrans", 32'(HTRANS), 32'h2);
        checkOutput("to_next_haddr",  32'(HADDR),  32'h08);
        tick();
        tick();
        checkOutput("to_next_ack",   32'(ack), 32'h1);
        checkOutput("to_next_rdata", rdata,    32'hCAFEF00D);
        tick();

        // Reset asserted during the data phase
        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 1'b1, 8'h30, 3'd2, 32'hA5A5A5A5);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        tick();
        checkOutput("mr_data_hwdata", HWDATA, 32'hA5A5A5A5);
        HREADY = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("mr_htrans", 32'(HTRANS), 32'h0);
        checkOutput("mr_hsel",   32'(HSEL),   32'h0);
        checkOutput("mr_haddr",  32'(HADDR),  32'h0);
        checkOutput("mr_hwdata", HWDATA,      32'h0);
        checkOutput("mr_hwrite", 32'(HWRITE), 32'h0);
        checkOutput("mr_hsize",  32'(HSIZE),  32'h0);
        checkOutput("mr_busy",   32'(busy),   32'h0);
        checkOutput("mr_rdata",  rdata,       32'h0);
        tick();
        HREADY = 1'b1;
        HRESETn = 1'b1;
        tick();
        checkOutput("mr_post_ack",  32'(ack),  32'h0);
        checkOutput("mr_post_err",  32'(err),  32'h0);
        checkOutput("mr_post_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("mr_post2_ack", 32'(ack), 32'h0);
        checkOutput("mr_post2_err", 32'(err), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h30, 3'd2, 32'h01020304);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0, 32'h0);
        checkOutput("mr_new_htrans", 32'(HTRANS), 32'h2);
        checkOutput("mr_new_haddr",  32'(HADDR),  32'h30);
        tick();
        checkOutput("mr_new_hwdata", HWDATA, 32'h01020304);
        tick();
        checkOutput("mr_new_ack", 32'(ack), 32'h1);
        checkOutput("mr_new_err", 32'(err), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
